// File: rtl/keypad_event_scheduler.sv
// Keypad event scheduler: per-button pending bits, round-robin
// arbiter and a small FIFO of key codes with sticky loss flag.
module keypad_event_scheduler #(
    parameter int NBTN  = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NBTN-1:0]            btn_rel,
    input  logic                       clr,
    input  logic                       key_ready,
    output logic                       key_valid,
    output logic [3:0]                 key_code,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       drop_flag
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [3:0] LAST = 4'(NBTN-1);
    localparam logic [NBTN-1:0] ONE = {{(NBTN-1){1'b0}}, 1'b1};

    logic [NBTN-1:0] pend_q, pend_d;
    logic [3:0]      rr_q, rr_d;
    logic [AW-1:0]   wr_q, wr_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            drop_q, drop_d;
    logic [3:0]      mem_q [DEPTH];

    logic            gnt_vld;
    logic            gnt;
    logic [3:0]      gnt_idx;
    logic [NBTN-1:0] gmask;
    logic            pop;

    // Descending scan: the last hit is the nearest button at or above rr_q.
    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt_idx = 4'd0;
        idx     = 0;
        for (int k = NBTN-1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NBTN) idx = idx - NBTN;
            if (pend_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx[3:0];
            end
        end
    end

    assign gnt   = gnt_vld && (cnt_q != FULL);
    assign gmask = gnt ? (ONE << gnt_idx) : '0;
    assign pop   = key_valid && key_ready;

    always_comb begin
        pend_d = (pend_q & ~gmask) | btn_rel;
        drop_d = drop_q | (|(btn_rel & pend_q & ~gmask));
        rr_d   = rr_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        if (gnt) begin
            rr_d = (gnt_idx == LAST) ? 4'd0 : gnt_idx + 4'd1;
            wr_d = wr_q + 1'b1;
        end
        if (pop) rd_d = rd_q + 1'b1;
        unique case ({gnt, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (clr) begin
            pend_d = '0;
            drop_d = 1'b0;
            rr_d   = 4'd0;
            wr_d   = '0;
            rd_d   = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q <= '0;
            drop_q <= 1'b0;
            rr_q   <= 4'd0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            drop_q <= drop_d;
            rr_q   <= rr_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'd0;
        end else if (gnt && !clr) begin
            mem_q[wr_q] <= gnt_idx;
        end
    end

    assign key_valid  = (cnt_q != '0);
    assign key_code   = key_valid ? mem_q[rd_q] : 4'd0;
    assign fifo_count = cnt_q;
    assign drop_flag  = drop_q;

endmodule

// File: doc/keypad_event_scheduler.md
KEYPAD_EVENT_SCHEDULER -- requirements
Module: keypad_event_scheduler

Interface
REQ-001 The block SHALL have parameter NBTN, default 12, giving the number of button release-pulse inputs (legal range 2..16).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the key-event FIFO depth (power of 2, at least 2).
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset, with ports in this order:
- clk  in  1  sole clock; all state updates on its rising edge.
- rstn  in  1  master asynchronous reset, active low.
- btn_rel  in  NBTN  one-cycle release pulses, one per button; bit i maps to key code i.
- clr  in  1  synchronous flush of all queued and pending events.
- key_ready  in  1  consumer accepts key_code this cycle.
- key_valid  out  1  key_code holds a queued event.
- key_code  out  4  button index of the FIFO head.
- fifo_count  out  clog2(DEPTH+1)  number of queued events.
- drop_flag  out  1  sticky flag: at least one release event was lost.

Function
REQ-004 The block SHALL hold one pending bit per button, pend[i], set on any edge where btn_rel[i]=1 is sampled.
REQ-005 The arbiter SHALL select combinationally from the registered pend bits, granting at most one button per cycle, and only when registered fifo_count < DEPTH.
REQ-006 Arbitration SHALL be round-robin: the search starts at pointer rr_ptr and proceeds upward modulo NBTN; after granting button g, rr_ptr SHALL become (g+1) mod NBTN.
REQ-007 On the edge ending a granted cycle, g SHALL be written to the FIFO tail and pend[g] SHALL clear, unless btn_rel[g]=1 on that same edge, in which case pend[g] SHALL remain 1 (the new event is preserved).
REQ-008 If btn_rel[i]=1 is sampled while pend[i]=1 and i is not granted that cycle, the event SHALL be lost and drop_flag SHALL be set.
REQ-009 Latency: btn_rel pulse sampled at edge E, no contention, FIFO empty -> key_valid=1 with the correct key_code after edge E+1.
REQ-010 key_valid SHALL equal (fifo_count != 0), and key_code SHALL equal the FIFO head entry, zero-extended to 4 bits.
REQ-011 A pop SHALL occur on an edge where key_valid=1 and key_ready=1; key_ready while key_valid=0 SHALL have no effect.
REQ-012 A simultaneous push and pop SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-013 Full condition: with fifo_count=DEPTH, no grant SHALL occur even if a pop happens that cycle; pending bits SHALL hold, with no loss other than per REQ-008.
REQ-014 FIFO pointers SHALL wrap modulo DEPTH, and fifo_count SHALL never exceed DEPTH or go below 0.
REQ-015 clr=1 SHALL, on that edge, zero all pend bits, empty the FIFO, clear drop_flag and set rr_ptr=0; btn_rel pulses and key_ready in the clr cycle SHALL be ignored.
REQ-016 drop_flag SHALL remain set until clr or reset.

Reset
REQ-017 While rstn=0, all outputs and state SHALL be zero immediately and asynchronously: key_valid=0, key_code=0, fifo_count=0, drop_flag=0, pend=0, rr_ptr=0, FIFO pointers=0.
REQ-018 Reset asserted mid-operation SHALL discard all pending and queued events; the first edge after rstn deasserts SHALL behave as a normal sampling edge.

Verification
REQ-019 Single key: pulse btn_rel[5] one cycle, key_ready=1 -> key_valid=1, key_code=5 after the next edge, high exactly one cycle, then fifo_count=0.
REQ-020 Simultaneous: pulse btn_rel[3], btn_rel[7] and btn_rel[11] together, key_ready=0, from reset -> FIFO order 3, 7, 11; fifo_count reaches 3; rr_ptr=0.
REQ-021 Fairness: with rr_ptr=4, keep pend[2] and pend[9] set -> grant 9 first, then 2.
REQ-022 Full/backpressure: DEPTH=4, key_ready=0, pulse keys 0..5 one per cycle -> fifo_count=4, pend[4]=pend[5]=1, drop_flag=0; then key_ready=1 -> outputs 0,1,2,3,4,5 in order.
REQ-023 Drop: with the FIFO full, pulse btn_rel[6] twice, 3 cycles apart -> drop_flag=1; then clr -> fifo_count=0, drop_flag=0, key_valid=0.
REQ-024 Async reset: assert rstn=0 between clock edges with fifo_count=2 -> key_valid=0 and fifo_count=0 before the next edge.
